// File: rtl/bw_pkg.sv
// Shared types and default sizing for the Baugh-Wooley MAC accumulator slice.
package bw_pkg;

   localparam int unsigned PROD_W_DEF  = 32;
   localparam int unsigned ACC_W_DEF   = 40;
   localparam int unsigned MAX_LEN_DEF = 256;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } state_t;

endpackage

// File: rtl/bw_mac_accumulator_if.sv
// Product-in / group-result-out handshake bundle for bw_mac_accumulator.
interface bw_mac_accumulator_if
   import bw_pkg::*;
#(
   parameter int unsigned PROD_W  = PROD_W_DEF,
   parameter int unsigned ACC_W   = ACC_W_DEF,
   parameter int unsigned MAX_LEN = MAX_LEN_DEF
);

   localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_product;
   logic              in_last;

   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_acc;
   logic [CNT_W-1:0]  out_count;
   logic              out_forced;
   logic              out_sat;

   // Producer of products and consumer of results
   modport master (
      output in_valid, in_product, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_count, out_forced, out_sat
   );

   // The accumulator itself
   modport slave (
      input  in_valid, in_product, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_count, out_forced, out_sat
   );

endinterface

// File: rtl/bw_acc_add.sv
// ACC_W two's-complement adder; saturating when BW_MAC_SAT_EN is defined, wrapping otherwise.
module bw_acc_add #(
   parameter int unsigned ACC_W = 40
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             ovf
);

   localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W-1:0] raw;

   assign raw = a + b;

`ifdef BW_MAC_SAT_EN
   // Like-signed operands producing an opposite-signed result have overflowed
   assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
   assign sum = ovf ? (a[ACC_W-1] ? SAT_MIN : SAT_MAX) : raw;
`else
   assign ovf = 1'b0;
   assign sum = raw;
`endif

endmodule

// File: rtl/bw_mac_accumulator.sv
// Group accumulator behind the 16x16 Baugh-Wooley multiplier: sums in_last-delimited product groups.
// Optional macro BW_MAC_SAT_EN selects saturating accumulation and a live out_sat flag.
module bw_mac_accumulator
   import bw_pkg::*;
#(
   parameter int unsigned PROD_W  = PROD_W_DEF,
   parameter int unsigned ACC_W   = ACC_W_DEF,
   parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
   input  logic         clk,
   input  logic         rst,
   bw_mac_accumulator_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

   if (ACC_W < PROD_W) begin : g_bad_acc_w
      $error("bw_mac_accumulator: ACC_W must be >= PROD_W");
   end
   if (MAX_LEN < 1) begin : g_bad_max_len
      $error("bw_mac_accumulator: MAX_LEN must be >= 1");
   end

   state_t           state;
   state_t           state_nxt;

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] count;
   logic             sat;

   logic             xfer;
   logic             hit_max;
   logic             close;
   logic [CNT_W-1:0] cnt_nxt;
   logic             sat_nxt;
   logic [ACC_W-1:0] add_a;
   logic [ACC_W-1:0] add_b;
   logic [ACC_W-1:0] add_sum;
   logic             add_ovf;

   // Handshake decodes depend on state only
   assign bus.in_ready  = (state != HOLD);
   assign bus.out_valid = (state == HOLD);
   assign xfer          = bus.in_valid && (state != HOLD);

   // First beat of a group starts from zero so one adder serves both IDLE and ACCUM
   assign add_a   = (state == IDLE) ? '0 : acc;
   assign add_b   = ACC_W'($signed(bus.in_product));
   assign cnt_nxt = ((state == IDLE) ? '0 : count) + CNT_W'(1);
   assign hit_max = (cnt_nxt == CNT_W'(MAX_LEN));
   assign close   = bus.in_last || hit_max;
   assign sat_nxt = ((state == IDLE) ? 1'b0 : sat) | add_ovf;

   bw_acc_add #(
      .ACC_W (ACC_W)
   ) u_add (
      .a   (add_a),
      .b   (add_b),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, ACCUM: begin
            if (xfer) begin
               state_nxt = close ? HOLD : ACCUM;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Running sum, term counter and the result registers captured on the closing beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc            <= '0;
         count          <= '0;
         sat            <= 1'b0;
         bus.out_acc    <= '0;
         bus.out_count  <= '0;
         bus.out_forced <= 1'b0;
         bus.out_sat    <= 1'b0;
      end else if (xfer) begin
         acc   <= add_sum;
         count <= cnt_nxt;
         sat   <= sat_nxt;
         if (close) begin
            bus.out_acc    <= add_sum;
            bus.out_count  <= cnt_nxt;
            bus.out_forced <= hit_max && !bus.in_last;
            bus.out_sat    <= sat_nxt;
         end
      end else if ((state == HOLD) && bus.out_ready) begin
         sat            <= 1'b0;
         bus.out_forced <= 1'b0;
         bus.out_sat    <= 1'b0;
      end
   end

endmodule

// File: doc/bw_mac_accumulator.md
Name: bw_mac_accumulator

Overview:
- Sequential stage directly downstream of the combinational 16x16 signed Baugh-Wooley multiplier.
- Consumes a stream of 32-bit signed products and accumulates each group, delimited by a last flag, into a wide signed sum (dot-product / FIR-tap reduction).
- Presents one registered result per group on a valid/ready output port.
- Upstream logic registers operands into the multiplier and drives this block's input handshake.

Parameters:
- PROD_W, 32: width of incoming signed product.
- ACC_W, 40: accumulator and result width. Must be greater than or equal to PROD_W.
- MAX_LEN, 256: maximum number of terms per group. The group is force-closed at this count.

Ports:
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: product beat valid.
- in_ready  out  1: block accepts a beat.
- in_product  in  PROD_W: signed product from the multiplier.
- in_last  in  1: beat closes the current group.
- out_valid  out  1: result valid.
- out_ready  in  1: downstream accepts the result.
- out_acc  out  ACC_W: signed group sum.
- out_count  out  $clog2(MAX_LEN+1): number of terms in the group.
- out_forced  out  1: group was closed by MAX_LEN, not by in_last.
- out_sat  out  1: group saturated. Only meaningful with the macro; otherwise tied 0.

Behaviour:
- Beat transfer occurs when in_valid && in_ready. in_ready is driven combinationally from state only; it never depends on in_valid.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On transfer: acc <= sext(in_product), count <= 1.
  - Go to HOLD if in_last or MAX_LEN==1; otherwise go to ACCUM.
- State ACCUM:
  - in_ready=1.
  - On transfer: acc <= acc + sext(in_product), count <= count+1.
  - Go to HOLD if in_last, or if count+1==MAX_LEN. In the MAX_LEN case without in_last, set forced=1.
  - No transfer: hold state and contents.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_acc, out_count, out_forced and out_sat are registered and stable until handshake.
  - On out_ready: go to IDLE and clear forced and sat.
- Latency: the result is visible on out_valid in the cycle after the closing beat's transfer edge. A new group's first beat is accepted in the cycle after out_ready handshake, giving 1 bubble per group.
- Throughput: 1 beat/cycle inside a group.
- Arithmetic: sign-extend PROD_W to ACC_W. Without the macro, the sum wraps modulo 2^ACC_W in two's complement.
- MAX_LEN boundary: the next beat after a forced close starts a new group. Its in_last is honoured normally.
- in_last while in HOLD: not possible because in_ready=0. Upstream holds its beat per the valid/ready rule.
- Reset (async, any state, including mid-group or in HOLD):
  - state=IDLE, acc=0, count=0, out_valid=0, out_acc=0, out_count=0, out_forced=0, out_sat=0.
  - A partial group is discarded, with no output.
  - in_ready=1 once state is IDLE.

Optional Feature:
- Macro: BW_MAC_SAT_EN.
- Defined:
  - Each addition saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Overflow is detected from the operand signs versus the result sign.
  - out_sat is sticky per group: set on any clamp, cleared on result handshake or reset.
  - Once clamped, subsequent terms continue from the clamped value.
- Undefined:
  - Wrapping add.
  - out_sat is constant 0. The port remains present so the interface is identical.

Decomposition:
- Shared package bw_pkg:
  - constants PROD_W_DEF=32, ACC_W_DEF=40, MAX_LEN_DEF=256;
  - state typedef {IDLE, ACCUM, HOLD}.
- Sub-module bw_acc_add: ACC_W adder with a sat/wrap selection controlled by BW_MAC_SAT_EN, with an overflow flag output.
- The top level holds the FSM, counter and output registers.

Test Plan:
1. Products 100, -30, 7 with last on the 3rd beat -> one cycle later: out_valid=1, out_acc=77, out_count=3, out_forced=0.
2. Single beat 0x8000_0000 with last -> out_acc=0xFF_8000_0000 (-2^31, ACC_W=40), out_count=1.
3. Result pending with out_ready low for 5 cycles, in_valid high -> in_ready=0 throughout, out_acc stable, no beat lost. After out_ready, the next group's beats sum correctly.
4. MAX_LEN=4, six beats of 1, last only on the 6th -> first result acc=4, count=4, forced=1; second result acc=2, count=2, forced=0.
5. ACC_W=34, five beats of 0x7FFF_FFFF with last:
   - with BW_MAC_SAT_EN -> out_acc=0x1_FFFF_FFFF, out_sat=1;
   - without -> out_acc=-6442450949 (mod 2^34), out_sat=0.
6. rst pulsed asynchronously after 2 of 4 beats -> out_valid=0 immediately, no result emitted. A following group 5, 5 with last -> acc=10, count=2.
